lupdate: RTL and testbench



---
 rtl/lupdate_if.sv | 10 +
 rtl/lupdate.sv | 180 ++++++++++++++++++
 tb/tb_lupdate.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lupdate_if.sv
// rtl/lupdate_if.sv - 134-bit LCM packet stream bundle (word strobe, word, packet valid, valid strobe)
interface lupdate_if;
  logic         data_wr;
  logic [133:0] data;
  logic         data_valid;
  logic         data_valid_wr;

  modport master (output data_wr, data, data_valid, data_valid_wr);
  modport slave  (input  data_wr, data, data_valid, data_valid_wr);
endinterface

// File: rtl/lupdate.sv
// rtl/lupdate.sv - beacon-update stage: 3-cycle forwarding pipeline that absorbs
// local beacon-update messages and latches their configuration fields.
module lupdate #(
  parameter logic [7:0]  LMID          = 8'd12,
  parameter logic [3:0]  UPD_TYPE      = 4'hd,
  parameter logic        DEF_DIRECTION = 1'b0,
  parameter logic [31:0] DEF_TB_PARA   = 32'd0,
  parameter logic [47:0] DEF_DMAC      = 48'd0,
  parameter logic [31:0] DEF_SLOT      = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  lupdate_if.slave    in_lu,
  lupdate_if.master   out_lu,
  input  logic [47:0] in_local_mac_id,
  output logic        direction,
  output logic [31:0] token_bucket_para,
  output logic [47:0] direct_mac_addr,
  output logic [31:0] time_slot_period,
  output logic        beacon_update_master,
  output logic [31:0] lu_update_cnt,
  output logic [31:0] lu_malformed_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_UPD} state_t;

  typedef struct packed {
    logic         wr;
    logic [133:0] data;
    logic         valid;
    logic         valid_wr;
    logic         drop;
  } stage_t;

  state_t       r_state, w_state_nxt;
  stage_t       r_s1, r_s2, r_s3;
  logic         r_p1, r_p2;
  logic [3:0]   r_wcnt;
  logic         r_pid;
  logic         r_cap;
  logic [47:0]  r_sh_dmac;
  logic         r_sh_dir;
  logic [31:0]  r_sh_tb, r_sh_slot;

  logic         w_wr, w_head, w_tail, w_match;
  logic [3:0]   w_idx;
  logic         w_is_upd, w_in_drop, w_cap, w_commit, w_malformed;
  logic         w_mark1, w_mark2;

  assign w_wr    = in_lu.data_wr;
  assign w_head  = w_wr && (in_lu.data[133:132] == 2'b01);
  assign w_tail  = w_wr && (in_lu.data[133:132] == 2'b10);
  assign w_idx   = w_head ? 4'd0 : r_wcnt;
  assign w_match = (in_lu.data[127:80] == in_local_mac_id) &&
                   (in_lu.data[31:16] == 16'h88f7) &&
                   (in_lu.data[11:8] == UPD_TYPE);

  // Words 0 and 1 of the packet being classified are the stages still tagged with its packet id
  assign w_mark1 = w_is_upd && r_s1.wr && (r_p1 == r_pid);
  assign w_mark2 = w_is_upd && r_s2.wr && (r_p2 == r_pid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_is_upd    = 1'b0;
    w_in_drop   = 1'b0;
    w_cap       = 1'b0;
    w_commit    = 1'b0;
    w_malformed = 1'b0;
    if (w_head) begin
      w_state_nxt = S_HDR;
      w_malformed = (r_state == S_UPD);
    end else if (w_wr) begin
      case (r_state)
        S_HDR: begin
          if (w_idx == 4'd2) begin
            w_is_upd    = w_match;
            w_in_drop   = w_match;
            w_state_nxt = w_match ? S_UPD : S_BODY;
          end
        end
        S_UPD: begin
          w_in_drop = 1'b1;
          w_cap     = (w_idx == 4'd6);
        end
        default: ;
      endcase
      if (w_tail) begin
        w_state_nxt = S_IDLE;
        if (w_in_drop) begin
          w_commit    = r_cap || w_cap;
          w_malformed = !(r_cap || w_cap);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_p1   <= 1'b0;
      r_p2   <= 1'b0;
      r_wcnt <= 4'd0;
      r_pid  <= 1'b0;
    end else begin
      if (w_head)
        r_wcnt <= 4'd1;
      else if (w_wr && r_wcnt != 4'hf)
        r_wcnt <= r_wcnt + 4'd1;
      if (w_head)
        r_pid <= ~r_pid;
      r_s1 <= '{wr: w_wr, data: in_lu.data, valid: in_lu.data_valid,
                valid_wr: in_lu.data_valid_wr, drop: w_in_drop};
      r_p1 <= w_head ? ~r_pid : r_pid;
      r_s2 <= '{wr: r_s1.wr, data: r_s1.data, valid: r_s1.valid,
                valid_wr: r_s1.valid_wr, drop: r_s1.drop | w_mark1};
      r_p2 <= r_p1;
      r_s3 <= '{wr: r_s2.wr, data: r_s2.data, valid: r_s2.valid,
                valid_wr: r_s2.valid_wr, drop: r_s2.drop | w_mark2};
    end
  end

  // A 7-word update captures and commits on the same tail word, so commit reads the bus directly then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap                <= 1'b0;
      r_sh_dmac            <= DEF_DMAC;
      r_sh_dir             <= DEF_DIRECTION;
      r_sh_tb              <= DEF_TB_PARA;
      r_sh_slot            <= DEF_SLOT;
      direction            <= DEF_DIRECTION;
      token_bucket_para    <= DEF_TB_PARA;
      direct_mac_addr      <= DEF_DMAC;
      time_slot_period     <= DEF_SLOT;
      beacon_update_master <= 1'b0;
      lu_update_cnt        <= 32'd0;
      lu_malformed_cnt     <= 32'd0;
    end else begin
      if (w_cap) begin
        r_sh_dmac <= in_lu.data[127:80];
        r_sh_dir  <= in_lu.data[79];
        r_sh_tb   <= in_lu.data[63:32];
        r_sh_slot <= in_lu.data[31:0];
      end
      if (w_head || w_tail)
        r_cap <= 1'b0;
      else if (w_cap)
        r_cap <= 1'b1;
      if (w_commit) begin
        if (r_cap) begin
          direct_mac_addr   <= r_sh_dmac;
          direction         <= r_sh_dir;
          token_bucket_para <= r_sh_tb;
          time_slot_period  <= r_sh_slot;
        end else begin
          direct_mac_addr   <= in_lu.data[127:80];
          direction         <= in_lu.data[79];
          token_bucket_para <= in_lu.data[63:32];
          time_slot_period  <= in_lu.data[31:0];
        end
        beacon_update_master <= ~beacon_update_master;
        lu_update_cnt        <= lu_update_cnt + 32'd1;
      end
      if (w_malformed)
        lu_malformed_cnt <= lu_malformed_cnt + 32'd1;
    end
  end

  assign out_lu.data_wr       = r_s3.wr & ~r_s3.drop;
  assign out_lu.data          = r_s3.data;
  assign out_lu.data_valid    = r_s3.valid;
  assign out_lu.data_valid_wr = r_s3.valid_wr & ~r_s3.drop;

endmodule

// File: tb/tb_lupdate.sv
// tb/tb_lupdate.sv - self-checking bench for lupdate: vector table, hand sequences, random packets vs packet-level model
module tb_lupdate;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] mac = 48'h000606020001;
  logic        direction, beacon_update_master;
  logic [31:0] token_bucket_para, time_slot_period, lu_update_cnt, lu_malformed_cnt;
  logic [47:0] direct_mac_addr;

  always #5 clk = ~clk;

  lupdate_if in_lu();
  lupdate_if out_lu();

  lupdate dut (
    .clk(clk), .rst_n(rst_n), .in_lu(in_lu), .out_lu(out_lu),
    .in_local_mac_id(mac), .direction(direction), .token_bucket_para(token_bucket_para),
    .direct_mac_addr(direct_mac_addr), .time_slot_period(time_slot_period),
    .beacon_update_master(beacon_update_master), .lu_update_cnt(lu_update_cnt),
    .lu_malformed_cnt(lu_malformed_cnt)
  );

  typedef struct {
    logic [133:0] data;
    logic         v;
    logic         vwr;
    int           cyc;
  } obs_t;

  typedef struct {
    string name;
    int    len;
    bit    mac_ok;
    bit    et_ok;
    bit    ty_ok;
    int    exp_fwd;
    int    exp_upd;
    int    exp_mal;
  } vec_t;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  obs_t         exp_q[$];
  obs_t         got_q[$];
  logic [133:0] pkt[$];
  logic         pkt_v[$];
  int           pkt_c[$];

  logic        m_dir, m_bm;
  logic [31:0] m_tb, m_slot, m_upd, m_mal;
  logic [47:0] m_dmac;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (out_lu.data_wr === 1'b1)
      got_q.push_back('{out_lu.data, out_lu.data_valid, out_lu.data_valid_wr, cyc});

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dir = 1'b0; m_bm = 1'b0; m_tb = 32'd0; m_slot = 32'd0;
    m_dmac = 48'd0; m_upd = 32'd0; m_mal = 32'd0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic build(input int len, input logic [47:0] dst, input logic [15:0] et,
                       input logic [3:0] ty, input logic [127:0] w6);
    logic [127:0] pl;
    logic [1:0]   ctl;
    logic [3:0]   rsv;
    pkt.delete(); pkt_v.delete(); pkt_c.delete();
    for (int i = 0; i < len; i++) begin
      pl = {$urandom, $urandom, $urandom, $urandom};
      if (i == 2) begin
        pl[127:80] = dst; pl[31:16] = et; pl[11:8] = ty;
      end
      if (i == 6) pl = w6;
      ctl = (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b11;
      rsv = 4'($urandom);
      pkt.push_back({ctl, rsv, pl});
      pkt_v.push_back(1'($urandom));
    end
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_lu.data_wr       = 1'b1;
      in_lu.data          = pkt[i];
      in_lu.data_valid    = pkt_v[i];
      in_lu.data_valid_wr = (pkt[i][133:132] == 2'b10);
      pkt_c.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_lu.data_wr       = 1'b0;
      in_lu.data_valid_wr = 1'b0;
    end
  endtask

  // Packet-level reference: an update is any packet reaching word 2 with a matching header
  task automatic model_pkt();
    logic [133:0] w;
    bit           upd;
    upd = 1'b0;
    if (pkt.size() >= 3) begin
      w = pkt[2];
      upd = (w[127:80] == mac) && (w[31:16] == 16'h88f7) && (w[11:8] == 4'hd);
    end
    if (!upd) begin
      for (int i = 0; i < pkt.size(); i++) begin
        w = pkt[i];
        exp_q.push_back('{w, pkt_v[i], w[133:132] == 2'b10, pkt_c[i] + 3});
      end
    end else if (pkt.size() >= 7) begin
      w = pkt[6];
      m_dmac = w[127:80]; m_dir = w[79]; m_tb = w[63:32]; m_slot = w[31:0];
      m_bm = ~m_bm; m_upd = m_upd + 1;
    end else begin
      m_mal = m_mal + 1;
    end
  endtask

  task automatic drain(input string tag);
    obs_t e, g;
    int   n;
    chk({tag, "_word_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"}, g.data, e.data);
      chk({tag, "_valid_bits"}, {g.v, g.vwr}, {e.v, e.vwr});
      chk({tag, "_cycle"}, g.cyc, e.cyc);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_direction"}, direction, m_dir);
    chk({tag, "_tb_para"}, token_bucket_para, m_tb);
    chk({tag, "_dmac"}, direct_mac_addr, m_dmac);
    chk({tag, "_slot"}, time_slot_period, m_slot);
    chk({tag, "_bmaster"}, beacon_update_master, m_bm);
    chk({tag, "_upd_cnt"}, lu_update_cnt, m_upd);
    chk({tag, "_mal_cnt"}, lu_malformed_cnt, m_mal);
  endtask

  task automatic chk_out_zero(input string tag);
    chk({tag, "_out_wr"}, out_lu.data_wr, 1'b0);
    chk({tag, "_out_data"}, out_lu.data, 134'd0);
    chk({tag, "_out_valid"}, out_lu.data_valid, 1'b0);
    chk({tag, "_out_vwr"}, out_lu.data_valid_wr, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [127:0] w6;
    logic [31:0]  u0, m0;
    int           f0, len;

    vecs[0] = '{"normal8",       8, 1'b0, 1'b1, 1'b1,  8, 0, 0};
    vecs[1] = '{"upd13",        13, 1'b1, 1'b1, 1'b1,  0, 1, 0};
    vecs[2] = '{"dmac_other13", 13, 1'b0, 1'b1, 1'b1, 13, 0, 0};
    vecs[3] = '{"upd5_short",    5, 1'b1, 1'b1, 1'b1,  0, 0, 1};
    vecs[4] = '{"bad_type",      8, 1'b1, 1'b1, 1'b0,  8, 0, 0};
    vecs[5] = '{"bad_ethertype", 8, 1'b1, 1'b0, 1'b1,  8, 0, 0};
    vecs[6] = '{"upd7_tail_w6",  7, 1'b1, 1'b1, 1'b1,  0, 1, 0};
    vecs[7] = '{"two_word",      2, 1'b1, 1'b1, 1'b1,  2, 0, 0};
    vecs[8] = '{"upd3_tail_w2",  3, 1'b1, 1'b1, 1'b1,  0, 0, 1};

    in_lu.data_wr = 1'b0; in_lu.data = '0; in_lu.data_valid = 1'b0; in_lu.data_valid_wr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_out_zero("reset");
    chk_regs("reset");

    build(5, 48'h111111111111, 16'h0800, 4'h1, 128'd0);
    send_n(5); model_pkt(); idle(6);
    drain("normal5");
    chk_regs("normal5");

    w6 = {48'hAABBCCDDEEFF, 1'b1, 15'b0, 32'h00010002, 32'd1000};
    build(13, mac, 16'h88f7, 4'hd, w6);
    send_n(13);
    chk("pre_commit_bmaster", beacon_update_master, 1'b0);
    @(posedge clk); #1;
    in_lu.data_wr = 1'b0; in_lu.data_valid_wr = 1'b0;
    chk("upd_dmac", direct_mac_addr, 48'hAABBCCDDEEFF);
    chk("upd_direction", direction, 1'b1);
    chk("upd_tb_para", token_bucket_para, 32'h00010002);
    chk("upd_slot", time_slot_period, 32'd1000);
    chk("upd_bmaster", beacon_update_master, 1'b1);
    chk("upd_cnt", lu_update_cnt, 32'd1);
    model_pkt(); idle(5);
    drain("upd13_exact");

    foreach (vecs[k]) begin
      u0 = lu_update_cnt; m0 = lu_malformed_cnt;
      w6 = {$urandom, $urandom, $urandom, $urandom};
      build(vecs[k].len, vecs[k].mac_ok ? mac : 48'h0A0B0C0D0E0F,
            vecs[k].et_ok ? 16'h88f7 : 16'h0800, vecs[k].ty_ok ? 4'hd : 4'h2, w6);
      send_n(vecs[k].len); model_pkt(); idle(6);
      f0 = got_q.size();
      chk({vecs[k].name, "_fwd"}, f0, vecs[k].exp_fwd);
      chk({vecs[k].name, "_upd_delta"}, lu_update_cnt - u0, vecs[k].exp_upd);
      chk({vecs[k].name, "_mal_delta"}, lu_malformed_cnt - m0, vecs[k].exp_mal);
      drain(vecs[k].name);
      chk_regs(vecs[k].name);
    end

    // Back-to-back: normal, update, 2-word with no idle cycles between them
    u0 = lu_update_cnt;
    build(4, 48'h222222222222, 16'h88f7, 4'hd, 128'd0); send_n(4); model_pkt();
    build(9, mac, 16'h88f7, 4'hd, {$urandom, $urandom, $urandom, $urandom}); send_n(9); model_pkt();
    build(2, mac, 16'h88f7, 4'hd, 128'd0); send_n(2); model_pkt();
    idle(6);
    chk("b2b_upd_delta", lu_update_cnt - u0, 32'd1);
    drain("b2b");
    chk_regs("b2b");

    // Head arrives while an update is still open: closed without commit
    build(9, mac, 16'h88f7, 4'hd, {$urandom, $urandom, $urandom, $urandom});
    send_n(5);
    m_mal = m_mal + 1;
    build(4, 48'h333333333333, 16'h0800, 4'h0, 128'd0); send_n(4); model_pkt();
    idle(6);
    drain("abandon");
    chk_regs("abandon");

    // Reset asserted during word 8 of an update
    build(13, mac, 16'h88f7, 4'hd, {$urandom, $urandom, $urandom, $urandom});
    send_n(8);
    @(posedge clk); #1;
    in_lu.data = pkt[8]; in_lu.data_wr = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_out_zero("midrst");
    chk_regs("midrst");
    @(posedge clk); #1;
    in_lu.data_wr = 1'b0; in_lu.data_valid_wr = 1'b0;
    rst_n = 1'b1;
    idle(4);
    chk_regs("post_rst");
    build(5, 48'h444444444444, 16'h88f7, 4'h1, 128'd0); send_n(5); model_pkt(); idle(6);
    drain("post_rst_pkt");

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(2, 14);
      build(len, ($urandom % 3 != 0) ? mac : 48'h0A0000000001,
            ($urandom % 5 != 0) ? 16'h88f7 : 16'h0806,
            ($urandom % 5 != 0) ? 4'hd : 4'h7,
            {$urandom, $urandom, $urandom, $urandom});
      send_n(len); model_pkt();
      idle($urandom_range(0, 2));
    end
    idle(6);
    drain("rand");
    chk_regs("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
